// File: rtl/lsu_mem_arb_bridge_if.sv
// rtl/lsu_mem_arb_bridge_if.sv - LSU-side and memory-side bundle for the N-to-1 LSU/memory bridge
interface lsu_mem_arb_bridge_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_LANES    = 4,
  parameter int WORD_SIZE    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int FLAGS_WIDTH  = 4,
  parameter int TAG_WIDTH    = 8
);
  localparam int CH_BITS       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MEM_TAG_WIDTH = TAG_WIDTH + CH_BITS;
  localparam int DATA_W        = WORD_SIZE * 8;

  logic [NUM_CHANNELS-1:0]                         in_req_valid;
  logic [NUM_CHANNELS-1:0]                         in_req_rw;
  logic [NUM_CHANNELS*NUM_LANES-1:0]               in_req_mask;
  logic [NUM_CHANNELS*NUM_LANES*WORD_SIZE-1:0]     in_req_byteen;
  logic [NUM_CHANNELS*NUM_LANES*ADDR_WIDTH-1:0]    in_req_addr;
  logic [NUM_CHANNELS*NUM_LANES*FLAGS_WIDTH-1:0]   in_req_flags;
  logic [NUM_CHANNELS*NUM_LANES*DATA_W-1:0]        in_req_data;
  logic [NUM_CHANNELS*TAG_WIDTH-1:0]               in_req_tag;
  logic [NUM_CHANNELS-1:0]                         in_req_ready;

  logic [NUM_CHANNELS-1:0]                         in_rsp_valid;
  logic [NUM_CHANNELS*NUM_LANES-1:0]               in_rsp_mask;
  logic [NUM_CHANNELS*NUM_LANES*DATA_W-1:0]        in_rsp_data;
  logic [NUM_CHANNELS*TAG_WIDTH-1:0]               in_rsp_tag;
  logic [NUM_CHANNELS-1:0]                         in_rsp_ready;

  logic                                            mem_req_valid;
  logic                                            mem_req_rw;
  logic [NUM_LANES-1:0]                            mem_req_mask;
  logic [NUM_LANES*WORD_SIZE-1:0]                  mem_req_byteen;
  logic [NUM_LANES*ADDR_WIDTH-1:0]                 mem_req_addr;
  logic [NUM_LANES*FLAGS_WIDTH-1:0]                mem_req_flags;
  logic [NUM_LANES*DATA_W-1:0]                     mem_req_data;
  logic [MEM_TAG_WIDTH-1:0]                        mem_req_tag;
  logic                                            mem_req_ready;

  logic                                            mem_rsp_valid;
  logic [NUM_LANES-1:0]                            mem_rsp_mask;
  logic [NUM_LANES*DATA_W-1:0]                     mem_rsp_data;
  logic [MEM_TAG_WIDTH-1:0]                        mem_rsp_tag;
  logic                                            mem_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_mask, in_req_byteen, in_req_addr,
           in_req_flags, in_req_data, in_req_tag,
    output in_req_ready,
    output in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready,
    output mem_req_valid, mem_req_rw, mem_req_mask, mem_req_byteen, mem_req_addr,
           mem_req_flags, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_mask, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_mask, in_req_byteen, in_req_addr,
           in_req_flags, in_req_data, in_req_tag,
    input  in_req_ready,
    input  in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag,
    output in_rsp_ready,
    input  mem_req_valid, mem_req_rw, mem_req_mask, mem_req_byteen, mem_req_addr,
           mem_req_flags, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_mask, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/lsu_mem_arb_bridge.sv
// rtl/lsu_mem_arb_bridge.sv - round-robin N-to-1 LSU request merge with tag-routed responses
module lsu_mem_arb_bridge #(
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_LANES    = 4,
  parameter int WORD_SIZE    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int FLAGS_WIDTH  = 4,
  parameter int TAG_WIDTH    = 8,
  parameter int MAX_PENDING  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  lsu_mem_arb_bridge_if.slave    bus,
  output logic                   busy,
  output logic                   rsp_err
);
  localparam int CH_BITS       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MEM_TAG_WIDTH = TAG_WIDTH + CH_BITS;
  localparam int CNT_W         = $clog2(MAX_PENDING + 1);
  localparam int DATA_W        = WORD_SIZE * 8;
  localparam int BE_W          = NUM_LANES * WORD_SIZE;
  localparam int ADDR_W        = NUM_LANES * ADDR_WIDTH;
  localparam int FLAGS_W       = NUM_LANES * FLAGS_WIDTH;
  localparam int WDATA_W       = NUM_LANES * DATA_W;

  logic [NUM_CHANNELS-1:0]             eligible;
  logic [NUM_CHANNELS-1:0]             grant;
  logic                                grant_any;
  logic [CH_BITS-1:0]                  grant_idx;
  int                                  gsel;
  logic                                accept;

  logic [CH_BITS-1:0]                  rr_q, rr_d;
  logic [NUM_CHANNELS-1:0][CNT_W-1:0]  pending_q, pending_d;
  logic                                rsp_err_q, rsp_err_d;

  logic                                out_valid_q, out_valid_d;
  logic                                out_rw_q, out_rw_d;
  logic [NUM_LANES-1:0]                out_mask_q, out_mask_d;
  logic [BE_W-1:0]                     out_byteen_q, out_byteen_d;
  logic [ADDR_W-1:0]                   out_addr_q, out_addr_d;
  logic [FLAGS_W-1:0]                  out_flags_q, out_flags_d;
  logic [WDATA_W-1:0]                  out_data_q, out_data_d;
  logic [MEM_TAG_WIDTH-1:0]            out_tag_q, out_tag_d;

  logic [CH_BITS-1:0]                  rsp_ch;
  logic [NUM_CHANNELS-1:0]             rsp_sel;
  logic                                rsp_in_range;
  logic                                rsp_fire;
  logic [NUM_CHANNELS-1:0]             cnt_inc;
  logic [NUM_CHANNELS-1:0]             cnt_dec;

  // A channel at its read limit may still issue writes; they never return a response.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = bus.in_req_valid[i] &&
                    !(!bus.in_req_rw[i] && pending_q[i] == CNT_W'(MAX_PENDING));
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(rr_q) + k) % NUM_CHANNELS;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = CH_BITS'(idx);
      end
    end
  end

  assign gsel   = int'(grant_idx);
  assign accept = !out_valid_q || bus.mem_req_ready;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      grant[i] = grant_any && (grant_idx == CH_BITS'(i));
    end
  end

  assign bus.in_req_ready = grant & {NUM_CHANNELS{accept}};

  always_comb begin
    out_valid_d  = out_valid_q;
    out_rw_d     = out_rw_q;
    out_mask_d   = out_mask_q;
    out_byteen_d = out_byteen_q;
    out_addr_d   = out_addr_q;
    out_flags_d  = out_flags_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    rr_d         = rr_q;
    if (accept) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_rw_d     = bus.in_req_rw[gsel];
        out_mask_d   = bus.in_req_mask[gsel*NUM_LANES +: NUM_LANES];
        out_byteen_d = bus.in_req_byteen[gsel*BE_W +: BE_W];
        out_addr_d   = bus.in_req_addr[gsel*ADDR_W +: ADDR_W];
        out_flags_d  = bus.in_req_flags[gsel*FLAGS_W +: FLAGS_W];
        out_data_d   = bus.in_req_data[gsel*WDATA_W +: WDATA_W];
        out_tag_d    = {grant_idx, bus.in_req_tag[gsel*TAG_WIDTH +: TAG_WIDTH]};
        rr_d         = (grant_idx == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign bus.mem_req_valid  = out_valid_q;
  assign bus.mem_req_rw     = out_rw_q;
  assign bus.mem_req_mask   = out_mask_q;
  assign bus.mem_req_byteen = out_byteen_q;
  assign bus.mem_req_addr   = out_addr_q;
  assign bus.mem_req_flags  = out_flags_q;
  assign bus.mem_req_data   = out_data_q;
  assign bus.mem_req_tag    = out_tag_q;

  // Responses route purely by the channel field the request stage prepended.
  assign rsp_ch = bus.mem_rsp_tag[MEM_TAG_WIDTH-1 -: CH_BITS];

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rsp_sel[i] = (rsp_ch == CH_BITS'(i));
    end
  end

  assign rsp_in_range      = |rsp_sel;
  assign bus.mem_rsp_ready = rsp_in_range ? |(rsp_sel & bus.in_rsp_ready) : 1'b1;
  assign rsp_fire          = bus.mem_rsp_valid && bus.mem_rsp_ready;
  assign bus.in_rsp_valid  = rsp_sel & {NUM_CHANNELS{bus.mem_rsp_valid}};
  assign bus.in_rsp_mask   = {NUM_CHANNELS{bus.mem_rsp_mask}};
  assign bus.in_rsp_data   = {NUM_CHANNELS{bus.mem_rsp_data}};
  assign bus.in_rsp_tag    = {NUM_CHANNELS{bus.mem_rsp_tag[TAG_WIDTH-1:0]}};

  assign cnt_inc = grant & {NUM_CHANNELS{accept}} & ~bus.in_req_rw;
  assign cnt_dec = rsp_sel & {NUM_CHANNELS{rsp_fire}};

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cnt_inc[i] && !cnt_dec[i]) begin
        pending_d[i] = pending_q[i] + 1'b1;
      end else if (cnt_dec[i] && !cnt_inc[i] && pending_q[i] != '0) begin
        pending_d[i] = pending_q[i] - 1'b1;
      end
    end
  end

  assign rsp_err_d = rsp_err_q || (bus.mem_rsp_valid && !rsp_in_range);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rr_q        <= '0;
      pending_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rr_q        <= rr_d;
      pending_q   <= pending_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    out_rw_q     <= out_rw_d;
    out_mask_q   <= out_mask_d;
    out_byteen_q <= out_byteen_d;
    out_addr_q   <= out_addr_d;
    out_flags_q  <= out_flags_d;
    out_data_q   <= out_data_d;
    out_tag_q    <= out_tag_d;
  end

  assign busy    = out_valid_q || (|pending_q);
  assign rsp_err = rsp_err_q;
endmodule
